fill_sequencer: RTL and testbench
=================================

# fill_sequencer

Sequencing controller for the pill-bottling datapath. It counts hopper pill pulses into the current bottle in BCD and closes each bottle at the target count. It also times the conveyor bottle-switch window, detects hopper starvation and conveyor faults, and exports the state code and BCD counters that drive the status digit and count digits. It sits between the edge-detected hopper pulse, the conveyor sensor, the operator buttons and the display/buzzer logic.

## Interface
Parameters:
- `TICK_HZ`, default 1000: clock cycles per second.
- `SWITCH_SEC`, default 2: bottle-switch window, in seconds.
- `STARVE_SEC`, default 5: maximum gap between pills while RUNNING, in seconds.

Ports:
- `clk_1khz` in 1: system clock; all logic is on the rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run (QD button).
- `abort` in 1: emergency-stop level.
- `ack` in 1: one-cycle pulse that leaves DONE or FATAL.
- `target_pills` in 12: BCD pills per bottle; digit[3:0] is the units digit.
- `target_bottles` in 8: BCD bottle count.
- `pill_pulse` in 1: one-cycle pulse per pill from the hopper edge detector.
- `conveyor_ok` in 1: conveyor-running sensor.
- `state` out 3: 0 SETTING, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL.
- `now_pills` out 12: BCD pills in the current bottle.
- `now_bottles` out 8: BCD completed bottles.
- `hopper_en` out 1: high iff `state` is RUNNING.
- `conveyor_run` out 1: high iff `state` is SWITCHING.
- `err_cause` out 2: 01 hopper starve, 10 conveyor fault, 00 otherwise.

## Operation
- **Reset:** `clr` sets `state`=SETTING and all outputs and internal registers to 0.
- **Abort priority:** `abort` high moves the block to FATAL from any state. This overrides every other event in the same cycle.
- **SETTING:** `start` is accepted only when all of the following hold:
  - both targets are nonzero;
  - every BCD digit is ≤9.
- **On an accepted start:**
  - latch the targets into internal registers; later input changes are ignored until the next start;
  - clear `now_pills` and `now_bottles`;
  - load the starve timer with STARVE_SEC·TICK_HZ−1;
  - go to RUNNING.
- **Rejected start:** no effect.
- **RUNNING:**
  - A `pill_pulse` increments `now_pills` with BCD carry and reloads the starve timer.
  - When the incremented value equals the latched pill target, the bottle closes:
    - `now_bottles` is BCD-incremented;
    - if the new bottle count equals the latched bottle target, go to DONE;
    - otherwise load the switch timer with SWITCH_SEC·TICK_HZ−1 and go to SWITCHING.
  - With no pulse, the starve timer decrements each cycle. When it is at 0, go to ERROR with `err_cause`=01.
- **SWITCHING:**
  - `now_pills` is cleared on entry.
  - `pill_pulse` is ignored.
  - The switch timer decrements each cycle. At 0:
    - if `conveyor_ok`=1, reload the starve timer and go to RUNNING;
    - otherwise go to ERROR with `err_cause`=10.
- **ERROR, cause 01:** the next `pill_pulse` returns to RUNNING. That pill is counted, including a possible bottle close in the same cycle, as in RUNNING.
- **ERROR, cause 10:** `conveyor_ok`=1 returns to RUNNING with the starve timer reloaded.
- **Leaving ERROR:** `err_cause` is cleared on exit.
- **DONE:** the counters hold. `ack` returns to SETTING.
- **FATAL:** the counters hold. `ack` with `abort`=0 returns to SETTING. `ack` while `abort`=1 is ignored.
- **start outside SETTING:** ignored.
- **Timer arithmetic:** timers are unsigned and at least ⌈log2(max(SWITCH_SEC,STARVE_SEC)·TICK_HZ)⌉ bits wide. They never wrap below 0.
- **Counter bounds:** BCD counters cannot exceed their targets (max 999 pills, 99 bottles), so no counter wrap occurs.

## Timing
- All outputs are registered. `hopper_en` and `conveyor_run` are decoded from the registered `state`.
- `pill_pulse` sampled at edge N:
  - `now_pills` and `now_bottles` update at edge N;
  - they are visible in cycle N+1 together with the new `state`.
- Simultaneous `pill_pulse` and starve-timer-at-0 in RUNNING: the pill wins. The block counts it, reloads the timer and does not go to ERROR.
- Timing-out durations:
  - starve timeout: exactly STARVE_SEC·TICK_HZ cycles after the last pill or after entry to RUNNING;
  - switch window: exactly SWITCH_SEC·TICK_HZ cycles in SWITCHING.
- `clr` asserted mid-run: immediate asynchronous return to SETTING with zeroed outputs. The first active edge after `clr` deasserts is a normal SETTING cycle.

## Configuration
- Macro: `FILL_SEQ_TOTAL_EN`.
- **When defined:** adds output `total_pills` (out 16), a binary count of every pill counted since `clr`.
  - It increments on each counted `pill_pulse`.
  - It saturates at 65535.
  - It is not cleared by `start`; it resets to 0 on `clr`.
- **When undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Normal fill:** targets 003 pills / 02 bottles, start, 3 pulses.
  - Required: SWITCHING, `now_bottles`=01, `now_pills`=000, for 2000 cycles.
  - With `conveyor_ok`=1: RUNNING.
  - Then 3 pulses: DONE with `now_bottles`=02.
  - `ack`: SETTING.
- **BCD carry:** target 012 pills / 01 bottle, 9 pulses then 1 more.
  - Required: `now_pills` reads 009, then 010.
  - After 2 more pulses: DONE.
- **Starvation:** RUNNING with no pulses for 5000 cycles.
  - Required: ERROR with `err_cause`=01 exactly at cycle 5000.
  - One pulse: RUNNING with `now_pills`=001.
  - A pulse in the same cycle as timeout: stays RUNNING.
- **Conveyor fault:** `conveyor_ok`=0 at switch expiry.
  - Required: ERROR with `err_cause`=10.
  - Raise `conveyor_ok`: RUNNING next cycle.
- **Abort:**
  - `abort` in SWITCHING: FATAL next cycle, counters held.
  - `ack` while `abort`=1: stays FATAL.
  - Drop `abort`, then `ack`: SETTING.
  - `clr` mid-RUNNING: all outputs 0 without waiting for a clock edge.
- **Rejected start:** target_pills=000, or any digit 0xA, with start.
  - Required: remains SETTING.
  - `FILL_SEQ_TOTAL_EN` build: `total_pills` equals the sum of pills counted across two runs.

Source files
------------

// File: rtl/fill_sequencer.sv
// fill_sequencer: sequencing controller for the pill-bottling datapath.
// Counts hopper pulses into the current bottle in BCD, closes bottles at the
// latched target, times the bottle-switch window and detects hopper starvation
// and conveyor faults. State code and BCD counters drive the display logic.
// Optional feature: define FILL_SEQ_TOTAL_EN to add the 16-bit total_pills
// output, a saturating binary count of every pill counted since clr.
module fill_sequencer #(
    parameter int TICK_HZ    = 1000,
    parameter int SWITCH_SEC = 2,
    parameter int STARVE_SEC = 5
) (
    input  logic        clk_1khz,
    input  logic        clr,
    input  logic        start,
    input  logic        abort,
    input  logic        ack,
    input  logic [11:0] target_pills,
    input  logic [7:0]  target_bottles,
    input  logic        pill_pulse,
    input  logic        conveyor_ok,
    output logic [2:0]  state,
    output logic [11:0] now_pills,
    output logic [7:0]  now_bottles,
    output logic        hopper_en,
    output logic        conveyor_run,
    output logic [1:0]  err_cause
`ifdef FILL_SEQ_TOTAL_EN
    ,
    output logic [15:0] total_pills
`endif
);

    localparam int STARVE_CYC = STARVE_SEC * TICK_HZ;
    localparam int SWITCH_CYC = SWITCH_SEC * TICK_HZ;
    localparam int MAX_CYC    = (STARVE_CYC > SWITCH_CYC) ? STARVE_CYC : SWITCH_CYC;
    localparam int TW         = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    // Timers count down to 0 inclusive, so N-1 gives exactly N cycles.
    localparam logic [TW-1:0] STARVE_LOAD = TW'(STARVE_CYC - 1);
    localparam logic [TW-1:0] SWITCH_LOAD = TW'(SWITCH_CYC - 1);

    typedef enum logic [2:0] {
        S_SETTING   = 3'd0,
        S_RUNNING   = 3'd1,
        S_SWITCHING = 3'd2,
        S_DONE      = 3'd3,
        S_ERROR     = 3'd4,
        S_FATAL     = 3'd5
    } state_t;

    state_t        state_reg;
    logic [11:0]   tgt_pills_reg;
    logic [7:0]    tgt_bottles_reg;
    logic [11:0]   pills_reg;
    logic [7:0]    bottles_reg;
    // One timer serves both the starve and the switch windows; they never overlap.
    logic [TW-1:0] timer_reg;
    logic [1:0]    err_cause_reg;

    logic [19:0]   target_digits;
    logic [4:0]    digit_ok;
    logic          start_ok;
    logic [11:0]   pills_next;
    logic [2:0]    pill_cy;
    logic [7:0]    bottles_next;
    logic [1:0]    bottle_cy;
    logic          pill_counted;

    genvar gi;

    // Every target digit must be a legal BCD digit before a start is accepted.
    assign target_digits = {target_bottles, target_pills};
    generate
        for (gi = 0; gi < 5; gi++) begin : g_digit_ok
            assign digit_ok[gi] = (target_digits[4*gi +: 4] <= 4'd9);
        end
    endgenerate
    assign start_ok = (&digit_ok) && (target_pills != 12'd0) && (target_bottles != 8'd0);

    // BCD +1 on the pill counter: ripple carry through digits that read 9.
    assign pill_cy[0] = 1'b1;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pill_inc
            logic [3:0] d;
            assign d = pills_reg[4*gi +: 4];
            assign pills_next[4*gi +: 4] = !pill_cy[gi] ? d :
                                           ((d == 4'd9) ? 4'd0 : d + 4'd1);
            if (gi < 2) begin : g_cy
                assign pill_cy[gi+1] = pill_cy[gi] && (d == 4'd9);
            end
        end
    endgenerate

    // BCD +1 on the bottle counter.
    assign bottle_cy[0] = 1'b1;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bottle_inc
            logic [3:0] d;
            assign d = bottles_reg[4*gi +: 4];
            assign bottles_next[4*gi +: 4] = !bottle_cy[gi] ? d :
                                             ((d == 4'd9) ? 4'd0 : d + 4'd1);
            if (gi < 1) begin : g_cy
                assign bottle_cy[gi+1] = bottle_cy[gi] && (d == 4'd9);
            end
        end
    endgenerate

    // A pill counts while RUNNING, or as the recovery pill out of a starve error.
    assign pill_counted = pill_pulse && !abort &&
                          ((state_reg == S_RUNNING) ||
                           ((state_reg == S_ERROR) && (err_cause_reg == 2'b01)));

    // Main sequencer: abort dominates, otherwise per-state counting and timing.
    always_ff @(posedge clk_1khz or posedge clr) begin
        if (clr) begin
            state_reg       <= S_SETTING;
            tgt_pills_reg   <= 12'd0;
            tgt_bottles_reg <= 8'd0;
            pills_reg       <= 12'd0;
            bottles_reg     <= 8'd0;
            timer_reg       <= '0;
            err_cause_reg   <= 2'b00;
        end else if (abort) begin
            state_reg     <= S_FATAL;
            err_cause_reg <= 2'b00;
        end else begin
            case (state_reg)
                S_SETTING: begin
                    if (start && start_ok) begin
                        tgt_pills_reg   <= target_pills;
                        tgt_bottles_reg <= target_bottles;
                        pills_reg       <= 12'd0;
                        bottles_reg     <= 8'd0;
                        timer_reg       <= STARVE_LOAD;
                        state_reg       <= S_RUNNING;
                    end
                end
                S_RUNNING, S_ERROR: begin
                    if (pill_counted) begin
                        err_cause_reg <= 2'b00;
                        timer_reg     <= STARVE_LOAD;
                        if (pills_next == tgt_pills_reg) begin
                            bottles_reg <= bottles_next;
                            if (bottles_next == tgt_bottles_reg) begin
                                pills_reg <= pills_next;
                                state_reg <= S_DONE;
                            end else begin
                                pills_reg <= 12'd0;
                                timer_reg <= SWITCH_LOAD;
                                state_reg <= S_SWITCHING;
                            end
                        end else begin
                            pills_reg <= pills_next;
                            state_reg <= S_RUNNING;
                        end
                    end else if (state_reg == S_RUNNING) begin
                        if (timer_reg == '0) begin
                            err_cause_reg <= 2'b01;
                            state_reg     <= S_ERROR;
                        end else begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end else if ((err_cause_reg == 2'b10) && conveyor_ok) begin
                        err_cause_reg <= 2'b00;
                        timer_reg     <= STARVE_LOAD;
                        state_reg     <= S_RUNNING;
                    end
                end
                S_SWITCHING: begin
                    if (timer_reg == '0) begin
                        if (conveyor_ok) begin
                            timer_reg <= STARVE_LOAD;
                            state_reg <= S_RUNNING;
                        end else begin
                            err_cause_reg <= 2'b10;
                            state_reg     <= S_ERROR;
                        end
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                S_DONE, S_FATAL: begin
                    if (ack) begin
                        state_reg <= S_SETTING;
                    end
                end
                default: state_reg <= S_SETTING;
            endcase
        end
    end

`ifdef FILL_SEQ_TOTAL_EN
    logic [15:0] total_reg;

    // Lifetime pill count; survives start, saturates instead of wrapping.
    always_ff @(posedge clk_1khz or posedge clr) begin
        if (clr) begin
            total_reg <= 16'd0;
        end else if (pill_counted && (total_reg != 16'hFFFF)) begin
            total_reg <= total_reg + 16'd1;
        end
    end

    assign total_pills = total_reg;
`endif

    assign state        = state_reg;
    assign now_pills    = pills_reg;
    assign now_bottles  = bottles_reg;
    assign err_cause    = err_cause_reg;
    assign hopper_en    = (state_reg == S_RUNNING);
    assign conveyor_run = (state_reg == S_SWITCHING);

endmodule

// File: tb/tb_fill_sequencer.sv
// Testbench for fill_sequencer: scenario tasks with randomized gaps and
// targets, checked against an integer-count reference model.
module tb_fill_sequencer;

    localparam int TICK_HZ    = 1000;
    localparam int SWITCH_SEC = 2;
    localparam int STARVE_SEC = 5;
    localparam int STARVE_CYC = STARVE_SEC * TICK_HZ;
    localparam int SWITCH_CYC = SWITCH_SEC * TICK_HZ;

    localparam int M_SET = 0, M_RUN = 1, M_SW = 2, M_DONE = 3, M_ERR = 4, M_FATAL = 5;

    logic        clk_1khz = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ack = 1'b0;
    logic [11:0] target_pills = 12'd0;
    logic [7:0]  target_bottles = 8'd0;
    logic        pill_pulse = 1'b0;
    logic        conveyor_ok = 1'b0;
    logic [2:0]  state;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic        hopper_en;
    logic        conveyor_run;
    logic [1:0]  err_cause;
`ifdef FILL_SEQ_TOTAL_EN
    logic [15:0] total_pills;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain integer counts and elapsed-cycle counters.
    int m_state, m_pills, m_bottles, m_tp, m_tb, m_wait, m_err, m_total;

    fill_sequencer #(
        .TICK_HZ   (TICK_HZ),
        .SWITCH_SEC(SWITCH_SEC),
        .STARVE_SEC(STARVE_SEC)
    ) dut (
        .clk_1khz      (clk_1khz),
        .clr           (clr),
        .start         (start),
        .abort         (abort),
        .ack           (ack),
        .target_pills  (target_pills),
        .target_bottles(target_bottles),
        .pill_pulse    (pill_pulse),
        .conveyor_ok   (conveyor_ok),
        .state         (state),
        .now_pills     (now_pills),
        .now_bottles   (now_bottles),
        .hopper_en     (hopper_en),
        .conveyor_run  (conveyor_run),
        .err_cause     (err_cause)
`ifdef FILL_SEQ_TOTAL_EN
        ,
        .total_pills   (total_pills)
`endif
    );

    always #5 clk_1khz = ~clk_1khz;

    function automatic int bcd_val(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic bit targets_ok(input logic [11:0] p, input logic [7:0] b);
        logic [19:0] all_d;
        all_d = {b, p};
        if (p == 12'd0 || b == 8'd0) return 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (all_d[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = M_SET; m_pills = 0; m_bottles = 0; m_tp = 0; m_tb = 0;
        m_wait = 0; m_err = 0; m_total = 0;
    endtask

    task automatic model_count();
        m_pills++;
        if (m_total < 65535) m_total++;
        m_err  = 0;
        m_wait = 0;
        if (m_pills == m_tp) begin
            m_bottles++;
            if (m_bottles == m_tb) m_state = M_DONE;
            else begin m_pills = 0; m_state = M_SW; end
        end else begin
            m_state = M_RUN;
        end
    endtask

    task automatic model_step();
        if (abort) begin
            m_state = M_FATAL;
            m_err   = 0;
        end else begin
            case (m_state)
                M_SET: if (start && targets_ok(target_pills, target_bottles)) begin
                    m_tp = bcd_val(target_pills);
                    m_tb = bcd_val({4'd0, target_bottles});
                    m_pills = 0; m_bottles = 0; m_wait = 0; m_state = M_RUN;
                end
                M_RUN: begin
                    if (pill_pulse) model_count();
                    else if (m_wait == STARVE_CYC - 1) begin m_state = M_ERR; m_err = 1; end
                    else m_wait++;
                end
                M_SW: begin
                    if (m_wait == SWITCH_CYC - 1) begin
                        if (conveyor_ok) begin m_state = M_RUN; m_wait = 0; end
                        else begin m_state = M_ERR; m_err = 2; end
                    end else m_wait++;
                end
                M_ERR: begin
                    if (m_err == 1 && pill_pulse) model_count();
                    else if (m_err == 2 && conveyor_ok) begin
                        m_state = M_RUN; m_err = 0; m_wait = 0;
                    end
                end
                M_DONE, M_FATAL: if (ack) m_state = M_SET;
                default: ;
            endcase
        end
    endtask

    // One clock: model follows the same sampled inputs, outputs read at negedge.
    task automatic tick();
        @(posedge clk_1khz);
        model_step();
        @(negedge clk_1khz);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pill();
        pill_pulse = 1'b1; tick(); pill_pulse = 1'b0;
    endtask

    task automatic start_run(input logic [11:0] tp, input logic [7:0] tb);
        target_pills = tp; target_bottles = tb;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk_1khz);
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if (now_pills !== 12'd0) $display("FAIL reset_pills: got %h want 000", now_pills); else n_pass++;
        n_total++; if (now_bottles !== 8'd0) $display("FAIL reset_bottles: got %h want 00", now_bottles); else n_pass++;
        n_total++; if (hopper_en !== 1'b0 || conveyor_run !== 1'b0) $display("FAIL reset_enables: got %b%b want 00", hopper_en, conveyor_run); else n_pass++;
        n_total++; if (err_cause !== 2'b00) $display("FAIL reset_err: got %b want 00", err_cause); else n_pass++;
        clr = 1'b0;
        model_reset();
        $display("reset: released");
    endtask

    task automatic test_rejected_start();
        logic [11:0] bad_p;
        logic [7:0]  bad_b;
        int pos;
        start_run(12'h000, 8'h01);
        n_total++; if (state !== 3'(m_state)) $display("FAIL reject_zero_pills: got %0d want %0d", state, m_state); else n_pass++;
        pos = $urandom_range(0, 2);
        bad_p = 12'h111;
        bad_p[4*pos +: 4] = 4'($urandom_range(10, 15));
        start_run(bad_p, 8'h01);
        n_total++; if (state !== 3'(m_state)) $display("FAIL reject_bad_pill_digit: got %0d want %0d (tp=%h)", state, m_state, bad_p); else n_pass++;
        bad_b = 8'h11;
        bad_b[4*(pos % 2) +: 4] = 4'($urandom_range(10, 15));
        start_run(12'h005, bad_b);
        n_total++; if (state !== 3'(m_state)) $display("FAIL reject_bad_bottle_digit: got %0d want %0d (tb=%h)", state, m_state, bad_b); else n_pass++;
        start_run(12'h005, 8'h00);
        n_total++; if (hopper_en !== (m_state == M_RUN)) $display("FAIL reject_zero_bottles: hopper_en got %b want %b", hopper_en, m_state == M_RUN); else n_pass++;
        $display("reject: start attempts done, state=%0d", state);
    endtask

    task automatic test_normal_fill();
        conveyor_ok = 1'b1;
        start_run(12'h003, 8'h02);
        n_total++; if (state !== 3'(m_state) || hopper_en !== 1'b1) $display("FAIL normal_start: got state %0d hop %b want %0d 1", state, hopper_en, m_state); else n_pass++;
        repeat (3) begin idle($urandom_range(0, 10)); pill(); $display("normal: pulse pills=%h bottles=%h state=%0d", now_pills, now_bottles, state); end
        n_total++; if (state !== 3'(m_state)) $display("FAIL normal_switch_state: got %0d want %0d", state, m_state); else n_pass++;
        n_total++; if (now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL normal_switch_bottles: got %h want %h", now_bottles, 8'(to_bcd(m_bottles))); else n_pass++;
        n_total++; if (now_pills !== to_bcd(m_pills)) $display("FAIL normal_switch_pills: got %h want %h", now_pills, to_bcd(m_pills)); else n_pass++;
        n_total++; if (conveyor_run !== 1'b1 || hopper_en !== 1'b0) $display("FAIL normal_switch_outputs: got run %b hop %b want 1 0", conveyor_run, hopper_en); else n_pass++;
        // A start with new targets outside SETTING and a stray pill both do nothing.
        target_pills = 12'h001; start = 1'b1; tick(); start = 1'b0;
        pill();
        idle(SWITCH_CYC - 3);
        n_total++; if (state !== 3'(m_state) || now_pills !== to_bcd(m_pills)) $display("FAIL normal_window_end: got %0d/%h want %0d/%h", state, now_pills, m_state, to_bcd(m_pills)); else n_pass++;
        tick();
        n_total++; if (state !== 3'(m_state)) $display("FAIL normal_resume: got %0d want %0d", state, m_state); else n_pass++;
        repeat (3) begin idle($urandom_range(0, 10)); pill(); end
        n_total++; if (state !== 3'(m_state) || now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL normal_done: got %0d/%h want %0d/%h", state, now_bottles, m_state, 8'(to_bcd(m_bottles))); else n_pass++;
        n_total++; if (now_pills !== to_bcd(m_pills)) $display("FAIL normal_done_pills: got %h want %h", now_pills, to_bcd(m_pills)); else n_pass++;
        ack = 1'b1; tick(); ack = 1'b0;
        n_total++; if (state !== 3'(m_state)) $display("FAIL normal_ack: got %0d want %0d", state, m_state); else n_pass++;
        $display("normal: fill complete, state=%0d", state);
    endtask

    task automatic test_bcd_carry();
        start_run(12'h012, 8'h01);
        repeat (9) begin idle($urandom_range(0, 4)); pill(); end
        n_total++; if (now_pills !== to_bcd(m_pills)) $display("FAIL carry_9: got %h want %h", now_pills, to_bcd(m_pills)); else n_pass++;
        pill();
        n_total++; if (now_pills !== to_bcd(m_pills)) $display("FAIL carry_10: got %h want %h", now_pills, to_bcd(m_pills)); else n_pass++;
        pill(); pill();
        n_total++; if (state !== 3'(m_state) || now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL carry_done: got %0d/%h want %0d/%h", state, now_bottles, m_state, 8'(to_bcd(m_bottles))); else n_pass++;
        ack = 1'b1; tick(); ack = 1'b0;
        $display("carry: pills=%h state=%0d", now_pills, state);
    endtask

    task automatic test_starvation();
        start_run(12'h005, 8'h01);
        idle(STARVE_CYC - 1);
        n_total++; if (state !== 3'(m_state)) $display("FAIL starve_early: got %0d want %0d", state, m_state); else n_pass++;
        tick();
        n_total++; if (state !== 3'(m_state) || err_cause !== 2'(m_err)) $display("FAIL starve_timeout: got %0d/%b want %0d/%b", state, err_cause, m_state, 2'(m_err)); else n_pass++;
        n_total++; if (hopper_en !== 1'b0) $display("FAIL starve_hopper: got %b want 0", hopper_en); else n_pass++;
        pill();
        n_total++; if (state !== 3'(m_state) || now_pills !== to_bcd(m_pills) || err_cause !== 2'(m_err)) $display("FAIL starve_recover: got %0d/%h/%b want %0d/%h/%b", state, now_pills, err_cause, m_state, to_bcd(m_pills), 2'(m_err)); else n_pass++;
        idle(STARVE_CYC - 1);
        pill();
        n_total++; if (state !== 3'(m_state) || now_pills !== to_bcd(m_pills)) $display("FAIL starve_tie: got %0d/%h want %0d/%h", state, now_pills, m_state, to_bcd(m_pills)); else n_pass++;
        pill(); pill();
        idle(STARVE_CYC);
        pill();
        n_total++; if (state !== 3'(m_state) || now_bottles !== 8'(to_bcd(m_bottles)) || err_cause !== 2'(m_err)) $display("FAIL starve_close: got %0d/%h/%b want %0d/%h/%b", state, now_bottles, err_cause, m_state, 8'(to_bcd(m_bottles)), 2'(m_err)); else n_pass++;
        ack = 1'b1; tick(); ack = 1'b0;
        $display("starve: recovery pill closed bottle, state=%0d", state);
    endtask

    task automatic test_conveyor_fault();
        conveyor_ok = 1'b0;
        start_run(12'h001, 8'h02);
        pill();
        idle(SWITCH_CYC);
        n_total++; if (state !== 3'(m_state) || err_cause !== 2'(m_err)) $display("FAIL conv_fault: got %0d/%b want %0d/%b", state, err_cause, m_state, 2'(m_err)); else n_pass++;
        pill();
        n_total++; if (state !== 3'(m_state) || now_pills !== to_bcd(m_pills)) $display("FAIL conv_pill_ignored: got %0d/%h want %0d/%h", state, now_pills, m_state, to_bcd(m_pills)); else n_pass++;
        conveyor_ok = 1'b1; tick();
        n_total++; if (state !== 3'(m_state) || err_cause !== 2'(m_err)) $display("FAIL conv_recover: got %0d/%b want %0d/%b", state, err_cause, m_state, 2'(m_err)); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        $display("conveyor: fault cleared, state=%0d", state);
    endtask

    task automatic test_abort();
        conveyor_ok = 1'b1;
        start_run(12'h002, 8'h03);
        pill(); pill();
        idle(5);
        abort = 1'b1; tick();
        n_total++; if (state !== 3'(m_state) || now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL abort_fatal: got %0d/%h want %0d/%h", state, now_bottles, m_state, 8'(to_bcd(m_bottles))); else n_pass++;
        n_total++; if (conveyor_run !== 1'b0) $display("FAIL abort_conveyor: got %b want 0", conveyor_run); else n_pass++;
        ack = 1'b1; tick(); ack = 1'b0;
        n_total++; if (state !== 3'(m_state)) $display("FAIL abort_ack_held: got %0d want %0d", state, m_state); else n_pass++;
        abort = 1'b0; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        n_total++; if (state !== 3'(m_state) || now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL abort_release: got %0d/%h want %0d/%h", state, now_bottles, m_state, 8'(to_bcd(m_bottles))); else n_pass++;
        $display("abort: back in state=%0d bottles=%h", state, now_bottles);
    endtask

    task automatic test_clr_async();
        start_run(12'h009, 8'h01);
        pill(); pill();
        n_total++; if (now_pills !== to_bcd(m_pills)) $display("FAIL clr_pre: got %h want %h", now_pills, to_bcd(m_pills)); else n_pass++;
        #2 clr = 1'b1;
        #1;
        n_total++; if (state !== 3'd0 || now_pills !== 12'd0 || hopper_en !== 1'b0) $display("FAIL clr_async: got %0d/%h/%b want 0/000/0", state, now_pills, hopper_en); else n_pass++;
        @(negedge clk_1khz);
        clr = 1'b0;
        model_reset();
        tick();
        n_total++; if (state !== 3'(m_state)) $display("FAIL clr_release: got %0d want %0d", state, m_state); else n_pass++;
        $display("clr: asynchronous clear observed");
    endtask

    task automatic test_random_fill();
        for (int run = 0; run < 2; run++) begin
            int tp;
            int tb;
            int budget;
            tp = $urandom_range(1, 25);
            tb = $urandom_range(1, 2);
            budget = 20000;
            conveyor_ok = 1'b1;
            start_run(to_bcd(tp), 8'(to_bcd(tb)));
            $display("random: run %0d target %0d pills x %0d bottles", run, tp, tb);
            while (m_state != M_DONE && budget > 0) begin
                if (m_state == M_RUN) begin
                    int gap;
                    gap = $urandom_range(0, 6);
                    idle(gap);
                    pill();
                    budget -= gap + 1;
                    n_total++; if (state !== 3'(m_state) || now_pills !== to_bcd(m_pills) || now_bottles !== 8'(to_bcd(m_bottles))) $display("FAIL random_pulse: got %0d/%h/%h want %0d/%h/%h", state, now_pills, now_bottles, m_state, to_bcd(m_pills), 8'(to_bcd(m_bottles))); else n_pass++;
                end else begin
                    pill_pulse = ($urandom_range(0, 9) == 0);
                    tick();
                    pill_pulse = 1'b0;
                    budget--;
                end
            end
            n_total++; if (state !== 3'd3) $display("FAIL random_done: got %0d want 3", state); else n_pass++;
            ack = 1'b1; tick(); ack = 1'b0;
        end
`ifdef FILL_SEQ_TOTAL_EN
        n_total++; if (total_pills !== 16'(m_total)) $display("FAIL total_pills: got %0d want %0d", total_pills, m_total); else n_pass++;
`endif
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_rejected_start();
        test_normal_fill();
        test_bcd_carry();
        test_starvation();
        test_conveyor_fault();
        test_abort();
        test_clr_async();
        test_random_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
